rv_ahb_rr_arb: RTL

- Round-robin AHB-lite bus arbiter sharing one system bus among NM masters, each driven by an RV AHB interface unit (fetch, load/store, debug).
- Tracks address-phase and data-phase ownership separately, so a new owner's address phase can overlap the previous owner's data phase.
- Routes the owner's address, TRANS and write data to the bus.
- Broadcasts read data to all masters.

---
 rtl/rv_ahb_rr_arb.sv | 112 +++++++++++
 1 files changed

// File: rtl/rv_ahb_rr_arb.sv
// Round-robin AHB-lite arbiter: registered address/data owners (grant 1 cycle after request), all state frozen while RDYBus=0.
// Define RV_AHB_ARB_PARK_EN to park an idle bus on master 0 instead of releasing the address grant.
module rv_ahb_rr_arb #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*NM-1:0]   TRANS,
    input  logic [NM-1:0]     LOCK,
    input  logic [AW*NM-1:0]  A,
    input  logic [DW*NM-1:0]  WD,
    output logic [DW-1:0]     RD,
    output logic [NM-1:0]     a_grant,
    output logic [NM-1:0]     d_grant,
    output logic [AW-1:0]     ABus,
    output logic [1:0]        TRANSBus,
    output logic [DW-1:0]     WDBus,
    input  logic [DW-1:0]     RDBus,
    input  logic              RDYBus
);

    localparam int OW = (NM > 1) ? $clog2(NM) : 1;

    logic [OW-1:0] a_owner_q, a_owner_d;
    logic [OW-1:0] d_owner_q, d_owner_d;
    logic          a_valid_q, a_valid_d;
    logic          d_valid_q, d_valid_d;

    logic [NM-1:0] req;
    logic [1:0]    trans_arr [NM];
    logic [AW-1:0] a_arr     [NM];
    logic [DW-1:0] wd_arr    [NM];

    for (genvar g = 0; g < NM; g++) begin : g_unpack
        assign trans_arr[g] = TRANS[2*g +: 2];
        assign a_arr[g]     = A[AW*g +: AW];
        assign wd_arr[g]    = WD[DW*g +: DW];
        assign req[g]       = TRANS[2*g+1];
    end

    // Scan starts one past the current owner so the owner itself is considered last.
    logic          rr_found;
    logic [OW-1:0] rr_owner;

    always_comb begin
        rr_found = 1'b0;
        rr_owner = a_owner_q;
        for (int i = 1; i <= NM; i++) begin
            if (!rr_found && req[(int'(a_owner_q) + i) % NM]) begin
                rr_found = 1'b1;
                rr_owner = OW'((int'(a_owner_q) + i) % NM);
            end
        end
    end

    always_comb begin
        a_owner_d = a_owner_q;
        a_valid_d = a_valid_q;
        d_owner_d = d_owner_q;
        d_valid_d = d_valid_q;
        if (RDYBus) begin
            d_valid_d = a_valid_q && TRANSBus[1];
            d_owner_d = a_owner_q;
            if (!(a_valid_q && LOCK[a_owner_q])) begin
                if (rr_found) begin
                    a_owner_d = rr_owner;
                    a_valid_d = 1'b1;
                end else begin
`ifdef RV_AHB_ARB_PARK_EN
                    a_owner_d = '0;
                    a_valid_d = 1'b1;
`else
                    a_valid_d = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_owner_q <= '0;
            d_owner_q <= '0;
            d_valid_q <= 1'b0;
`ifdef RV_AHB_ARB_PARK_EN
            a_valid_q <= 1'b1;
`else
            a_valid_q <= 1'b0;
`endif
        end else begin
            a_owner_q <= a_owner_d;
            a_valid_q <= a_valid_d;
            d_owner_q <= d_owner_d;
            d_valid_q <= d_valid_d;
        end
    end

    always_comb begin
        a_grant = '0;
        d_grant = '0;
        if (a_valid_q) a_grant[a_owner_q] = 1'b1;
        if (d_valid_q) d_grant[d_owner_q] = 1'b1;
    end

    assign ABus     = a_arr[a_owner_q];
    assign TRANSBus = a_valid_q ? trans_arr[a_owner_q] : 2'b00;
    assign WDBus    = wd_arr[d_owner_q];
    assign RD       = RDBus;

endmodule
